// File: rtl/csr_pkg.sv
// Shared types and constants for the Zicsr access controller.
package csr_pkg;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_ctrl_state_t;

  // CSR addresses with this top field are read-only.
  localparam logic [1:0] CSR_RO_BITS = 2'b11;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request, CSR-file and response signals of the Zicsr access controller.
interface csr_access_ctrl_if #(parameter int XLEN = 32);
  logic            i_req_valid;
  logic            o_req_ready;
  logic [2:0]      i_funct3;
  logic [11:0]     i_csr_id;
  logic [XLEN-1:0] i_rs1_data;
  logic [4:0]      i_rs1_idx;
  logic [11:0]     o_csr_id;
  logic            i_csr_hit;
  logic [XLEN-1:0] i_csr_rdata;
  logic            o_csr_we;
  logic [XLEN-1:0] o_csr_wdata;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [XLEN-1:0] o_rsp_rdata;
  logic            o_rsp_illegal;

  modport slave (
    input  i_req_valid, i_funct3, i_csr_id, i_rs1_data, i_rs1_idx,
    input  i_csr_hit, i_csr_rdata, i_rsp_ready,
    output o_req_ready, o_csr_id, o_csr_we, o_csr_wdata,
    output o_rsp_valid, o_rsp_rdata, o_rsp_illegal
  );

  modport master (
    output i_req_valid, i_funct3, i_csr_id, i_rs1_data, i_rs1_idx,
    output i_csr_hit, i_csr_rdata, i_rsp_ready,
    input  o_req_ready, o_csr_id, o_csr_we, o_csr_wdata,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_illegal
  );
endinterface

// File: rtl/csr_alu.sv
// Combinational read-modify-write value computation for Zicsr ops.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] new_val,
  output logic            do_write
);

  always_comb begin
    new_val  = '0;
    do_write = 1'b0;
    case (op)
      CSR_RW, CSR_RWI: begin
        new_val  = operand;
        do_write = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        new_val  = old_val | operand;
        do_write = (rs1_idx != 5'd0);
      end
      CSR_RC, CSR_RCI: begin
        new_val  = old_val & ~operand;
        do_write = (rs1_idx != 5'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one Zicsr read-modify-write against the CSR file per request.
//   state | meaning
//   IDLE  | ready for a request, latches operands on accept
//   READ  | CSR file addressed, old value / hit sampled, result computed
//   WRITE | write strobe issued if the access writes and is legal
//   RESP  | response held until the consumer accepts it
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  csr_access_ctrl_if.slave bus
);

  csr_ctrl_state_t state_q, state_d;

  logic [2:0]      funct3_q;
  logic [11:0]     csr_id_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            illegal_q;

  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  logic            illegal;

  assign operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op       (funct3_q),
    .old_val  (bus.i_csr_rdata),
    .operand  (operand),
    .rs1_idx  (rs1_idx_q),
    .new_val  (new_val),
    .do_write (do_write)
  );

  assign illegal = !funct3_legal(funct3_q) || !bus.i_csr_hit ||
                   (do_write && (csr_id_q[11:10] == CSR_RO_BITS));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q   <= '0;
      csr_id_q   <= '0;
      rs1_data_q <= '0;
      rs1_idx_q  <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.i_req_valid) begin
        funct3_q   <= bus.i_funct3;
        csr_id_q   <= bus.i_csr_id;
        rs1_data_q <= bus.i_rs1_data;
        rs1_idx_q  <= bus.i_rs1_idx;
      end
      if (state_q == ST_READ) begin
        // Illegal accesses must not leak the CSR contents.
        old_q     <= illegal ? '0 : bus.i_csr_rdata;
        wdata_q   <= new_val;
        we_q      <= do_write && !illegal;
        illegal_q <= illegal;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.o_req_ready   = 1'b0;
    bus.o_csr_we      = 1'b0;
    bus.o_rsp_valid   = 1'b0;
    bus.o_rsp_rdata   = '0;
    bus.o_rsp_illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        bus.o_csr_we = we_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        bus.o_rsp_valid   = 1'b1;
        bus.o_rsp_rdata   = old_q;
        bus.o_rsp_illegal = illegal_q;
        if (bus.i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_csr_id    = csr_id_q;
  assign bus.o_csr_wdata = wdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed and randomized checks of csr_access_ctrl against a rule-level model.
module tb_csr_access_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  csr_access_ctrl_if #(.XLEN(32)) bus ();

  csr_access_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic scramble_req();
    bus.i_funct3   = 3'($urandom);
    bus.i_csr_id   = 12'($urandom);
    bus.i_rs1_data = $urandom;
    bus.i_rs1_idx  = 5'($urandom);
  endtask

  // One full transaction; expectations come straight from the Zicsr rules.
  task automatic run_req(input logic [2:0] f3, input logic [11:0] id,
                         input logic [31:0] rs1, input logic [4:0] idx,
                         input logic [31:0] old, input logic hit, input int hold);
    logic [31:0] opnd, nv, exp_rd;
    logic        dw, ill, ewe;
    opnd = f3[2] ? {27'd0, idx} : rs1;
    dw   = (f3[1:0] == 2'b01) ? 1'b1 : (idx != 5'd0);
    case (f3[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = old | opnd;
      2'b11:   nv = old & ~opnd;
      default: nv = 32'd0;
    endcase
    ill    = (f3[1:0] == 2'b00) || !hit || (dw && id[11:10] == 2'b11);
    ewe    = dw && !ill;
    exp_rd = ill ? 32'd0 : old;

    @(negedge clk);
    check("idle_ready", 32'(bus.o_req_ready), 32'd1);
    bus.i_funct3    = f3;
    bus.i_csr_id    = id;
    bus.i_rs1_data  = rs1;
    bus.i_rs1_idx   = idx;
    bus.i_csr_hit   = hit;
    bus.i_csr_rdata = old;
    bus.i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    scramble_req();

    @(negedge clk);
    check("read_we", 32'(bus.o_csr_we), 32'd0);
    check("read_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("read_csr_id", 32'(bus.o_csr_id), 32'(id));

    @(negedge clk);
    bus.i_csr_hit   = 1'($urandom);
    bus.i_csr_rdata = $urandom;
    check("write_we", 32'(bus.o_csr_we), 32'(ewe));
    if (ewe) check("write_wdata", bus.o_csr_wdata, nv);
    check("write_csr_id", 32'(bus.o_csr_id), 32'(id));
    check("write_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);

    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      check("rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("rsp_rdata", bus.o_rsp_rdata, exp_rd);
      check("rsp_illegal", 32'(bus.o_rsp_illegal), 32'(ill));
      check("rsp_req_ready", 32'(bus.o_req_ready), 32'd0);
      check("rsp_we", 32'(bus.o_csr_we), 32'd0);
      if (k < hold) begin
        scramble_req();
        bus.i_req_valid = 1'b1;
        @(negedge clk);
      end
    end
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.o_req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [4:0]  ridx;
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    bus.i_csr_hit   = 1'b0;
    bus.i_csr_rdata = 32'd0;
    scramble_req();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_we", 32'(bus.o_csr_we), 32'd0);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
    check("rst_rsp_illegal", 32'(bus.o_rsp_illegal), 32'd0);
    check("rst_csr_id", 32'(bus.o_csr_id), 32'd0);
    check("rst_wdata", bus.o_csr_wdata, 32'd0);
    reset = 1'b0;

    run_req(3'b010, 12'hC00, 32'h1111_2222, 5'd0,  32'h0000_1234, 1'b1, 0);
    run_req(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5,  32'h0000_0005, 1'b1, 0);
    run_req(3'b011, 12'h340, 32'h0000_000F, 5'd3,  32'h0000_00FF, 1'b1, 0);
    run_req(3'b110, 12'h340, 32'hFFFF_FFFF, 5'h10, 32'h0000_00F0, 1'b1, 0);
    run_req(3'b101, 12'hC80, 32'h0,         5'd7,  32'h0000_0042, 1'b1, 0);
    run_req(3'b100, 12'h300, 32'h1234_5678, 5'd1,  32'h0000_0042, 1'b1, 0);
    run_req(3'b000, 12'h300, 32'h1234_5678, 5'd1,  32'h0000_0042, 1'b1, 0);
    run_req(3'b001, 12'h305, 32'hCAFE_0000, 5'd2,  32'h0000_0077, 1'b0, 0);
    run_req(3'b111, 12'h341, 32'h0,         5'h1F, 32'hAAAA_5555, 1'b1, 3);

    // Reset while a CSRRW sits in WRITE.
    @(negedge clk);
    bus.i_funct3    = 3'b001;
    bus.i_csr_id    = 12'h340;
    bus.i_rs1_data  = 32'h0BAD_F00D;
    bus.i_rs1_idx   = 5'd4;
    bus.i_csr_hit   = 1'b1;
    bus.i_csr_rdata = 32'h0000_0009;
    bus.i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_we_before", 32'(bus.o_csr_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_we", 32'(bus.o_csr_we), 32'd0);
    check("rstw_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rstw_req_ready", 32'(bus.o_req_ready), 32'd1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstw_idle_rsp", 32'(bus.o_rsp_valid), 32'd0);
      check("rstw_idle_we", 32'(bus.o_csr_we), 32'd0);
    end
    run_req(3'b001, 12'h340, 32'h1357_9BDF, 5'd6, 32'h0000_0009, 1'b1, 1);

    for (int n = 0; n < 40; n++) begin
      rf3  = 3'($urandom);
      ridx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_req(rf3, 12'($urandom), $urandom, ridx, $urandom,
              ($urandom_range(0, 7) != 0), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
